rule90_sequencer: RTL and testbench

Run controller for the 512-cell Rule 90 cellular-automaton core. It accepts a seed and a generation count, loads the seed into the core, and steps the core one generation per accepted snapshot. Each generation is streamed out on a valid/ready snapshot port. When the consumer stalls, the core is frozen by recirculating its own state through the load path, because the core has no enable. The block sits in the parent wrapper between the command source and the core instance.

---
 rtl/rule90_pkg.sv | 13 +
 rtl/rule90_sequencer.sv | 117 +++++++++++
 tb/tb_rule90_sequencer.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/rule90_pkg.sv
// Shared definitions for the Rule 90 core wrapper and its run sequencer.
package rule90_pkg;

  localparam int RULE90_WIDTH = 512;
  localparam int RULE90_GEN_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/rule90_sequencer.sv
// Run controller for the Rule 90 core: seeds it, steps it once per accepted snapshot.
// Optional all-zero early stop enabled by defining RULE90_SEQ_EXTINCT_EN.
module rule90_sequencer
  import rule90_pkg::*;
#(
  parameter int WIDTH = RULE90_WIDTH,
  parameter int GEN_W = RULE90_GEN_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_seed,
  input  logic [GEN_W-1:0] cmd_gens,
  input  logic             abort,
  output logic             ca_load,
  output logic [WIDTH-1:0] ca_data,
  input  logic [WIDTH-1:0] ca_q,
  output logic             snap_valid,
  input  logic             snap_ready,
  output logic [WIDTH-1:0] snap_data,
  output logic [GEN_W-1:0] snap_gen,
  output logic             snap_last,
  output logic             busy,
  output logic             done,
  output logic             extinct
);

  seq_state_t       r_state;
  seq_state_t       w_state_next;
  logic [GEN_W-1:0] r_gen;
  logic [GEN_W-1:0] r_gens;
  logic             r_extinct;
  logic             w_zero;
  logic             w_last;

`ifdef RULE90_SEQ_EXTINCT_EN
  assign w_zero = ~|ca_q;
`else
  assign w_zero = 1'b0;
`endif

  assign w_last = (r_state == ST_RUN) && ((r_gen == r_gens) || w_zero);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // The core has no enable: holding it means reloading its own state.
  always_comb begin
    w_state_next = r_state;
    ca_load      = 1'b1;
    ca_data      = ca_q;
    if (!reset) begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            ca_data      = cmd_seed;
            w_state_next = ST_RUN;
          end
        end
        ST_RUN: begin
          if (abort) begin
            w_state_next = ST_IDLE;
          end else if (snap_ready) begin
            if (w_last) begin
              w_state_next = ST_DONE;
            end else begin
              ca_load = 1'b0;
            end
          end
        end
        ST_DONE: begin
          w_state_next = ST_IDLE;
        end
        default: begin
          w_state_next = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_gen     <= '0;
      r_gens    <= '0;
      r_extinct <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && cmd_valid) begin
        r_gens    <= cmd_gens;
        r_gen     <= '0;
        r_extinct <= 1'b0;
      end else if (r_state == ST_RUN && snap_ready) begin
        // The last index never increments, so the counter cannot wrap.
        if (w_last) begin
          r_extinct <= w_zero & ~abort;
        end else begin
          r_gen <= r_gen + GEN_W'(1);
        end
      end
    end
  end

  assign cmd_ready  = (r_state == ST_IDLE);
  assign snap_valid = (r_state == ST_RUN);
  assign busy       = (r_state == ST_RUN);
  assign done       = (r_state == ST_DONE);
  assign snap_data  = ca_q;
  assign snap_gen   = r_gen;
  assign snap_last  = w_last;
  assign extinct    = r_extinct;

endmodule

// File: tb/tb_rule90_sequencer.sv
// Directed bench for rule90_sequencer with a behavioural Rule 90 core (null boundaries).
module tb_rule90_sequencer;
  localparam int W = 512;
  localparam int G = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [W-1:0] cmd_seed;
  logic [G-1:0] cmd_gens;
  logic         abort;
  logic         ca_load;
  logic [W-1:0] ca_data;
  logic [W-1:0] ca_q = '0;
  logic         snap_valid;
  logic         snap_ready;
  logic [W-1:0] snap_data;
  logic [G-1:0] snap_gen;
  logic         snap_last;
  logic         busy;
  logic         done;
  logic         extinct;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] one;
  logic [W-1:0] g0, g1, g2, g3, g4, a5;

  always #5 clk = ~clk;

  // Core model: load path or one Rule 90 step, next[i] = q[i-1] ^ q[i+1].
  always_ff @(posedge clk) begin
    if (ca_load) ca_q <= ca_data;
    else         ca_q <= (ca_q << 1) ^ (ca_q >> 1);
  end

  rule90_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_seed   (cmd_seed),
    .cmd_gens   (cmd_gens),
    .abort      (abort),
    .ca_load    (ca_load),
    .ca_data    (ca_data),
    .ca_q       (ca_q),
    .snap_valid (snap_valid),
    .snap_ready (snap_ready),
    .snap_data  (snap_data),
    .snap_gen   (snap_gen),
    .snap_last  (snap_last),
    .busy       (busy),
    .done       (done),
    .extinct    (extinct)
  );

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_cmd_ready"}, W'(cmd_ready), W'(1));
    check_eq({tag, "_snap_valid"}, W'(snap_valid), '0);
    check_eq({tag, "_snap_last"}, W'(snap_last), '0);
    check_eq({tag, "_busy"}, W'(busy), '0);
    check_eq({tag, "_done"}, W'(done), '0);
    check_eq({tag, "_extinct"}, W'(extinct), '0);
    check_eq({tag, "_ca_load"}, W'(ca_load), W'(1));
    check_eq({tag, "_ca_data"}, ca_data, ca_q);
  endtask

  // Present a command for one cycle; the DUT is expected to be idle.
  task automatic start_cmd(input string tag, input logic [W-1:0] seed, input logic [G-1:0] gens);
    check_eq({tag, "_ready"}, W'(cmd_ready), W'(1));
    cmd_seed  = seed;
    cmd_gens  = gens;
    cmd_valid = 1'b1;
    #1;
    check_eq({tag, "_seed_path"}, ca_data, seed);
    step();
    cmd_valid = 1'b0;
    $display("cmd %s gens=%0d", tag, gens);
  endtask

  // Check the presented snapshot, then let the edge pass with the current snap_ready.
  task automatic snap(input string tag, input int gen, input logic [W-1:0] data, input logic last);
    check_eq({tag, "_valid"}, W'(snap_valid), W'(1));
    check_eq({tag, "_gen"}, W'(snap_gen), W'(gen));
    check_eq({tag, "_data"}, snap_data, data);
    check_eq({tag, "_last"}, W'(snap_last), W'(last));
    $display("snap %s gen=%0d last=%0d ready=%0d", tag, snap_gen, snap_last, snap_ready);
    step();
  endtask

  task automatic check_end(input string tag, input logic exp_ext);
    check_eq({tag, "_done"}, W'(done), W'(1));
    check_eq({tag, "_cmd_ready_low"}, W'(cmd_ready), '0);
    check_eq({tag, "_extinct"}, W'(extinct), W'(exp_ext));
    step();
    check_eq({tag, "_done_clear"}, W'(done), '0);
    check_eq({tag, "_cmd_ready_back"}, W'(cmd_ready), W'(1));
    check_eq({tag, "_extinct_held"}, W'(extinct), W'(exp_ext));
  endtask

  initial begin
    one = 1;
    g0 = one << 256;
    g1 = (one << 255) | (one << 257);
    g2 = (one << 254) | (one << 258);
    g3 = (one << 253) | (one << 255) | (one << 257) | (one << 259);
    g4 = (one << 252) | (one << 260);
    a5 = W'(8'hA5);

    reset = 1'b1; cmd_valid = 1'b0; cmd_seed = '0; cmd_gens = '0;
    abort = 1'b0; snap_ready = 1'b1;
    step(); step();
    check_reset_outputs("reset");
    reset = 1'b0;
    step();

    // Basic run
    start_cmd("basic", g0, G'(3));
    snap("basic_g0", 0, g0, 1'b0);
    snap("basic_g1", 1, g1, 1'b0);
    snap("basic_g2", 2, g2, 1'b0);
    snap("basic_g3", 3, g3, 1'b1);
    check_end("basic_end", 1'b0);

    // Backpressure on gen1
    start_cmd("bp", g0, G'(3));
    snap("bp_g0", 0, g0, 1'b0);
    snap_ready = 1'b0;
    #1;
    check_eq("bp_hold_load", W'(ca_load), W'(1));
    for (int i = 0; i < 5; i++) snap("bp_stall", 1, g1, 1'b0);
    snap_ready = 1'b1;
    snap("bp_g1", 1, g1, 1'b0);
    snap("bp_g2", 2, g2, 1'b0);
    snap("bp_g3", 3, g3, 1'b1);
    check_end("bp_end", 1'b0);

    // Extinction
    start_cmd("ext", '0, G'(10));
`ifdef RULE90_SEQ_EXTINCT_EN
    snap("ext_g0", 0, '0, 1'b1);
    check_end("ext_end", 1'b1);
`else
    for (int i = 0; i < 10; i++) snap("ext_g", i, '0, 1'b0);
    snap("ext_g10", 10, '0, 1'b1);
    check_end("ext_end", 1'b0);
`endif

    // Single snapshot
    start_cmd("single", a5, G'(0));
    snap("single_g0", 0, a5, 1'b1);
    check_end("single_end", 1'b0);

    // Abort at gen2
    start_cmd("abort", g0, G'(8));
    snap("abort_g0", 0, g0, 1'b0);
    snap("abort_g1", 1, g1, 1'b0);
    abort = 1'b1;
    #1;
    check_eq("abort_load", W'(ca_load), W'(1));
    snap("abort_g2", 2, g2, 1'b0);
    abort = 1'b0;
    check_eq("abort_idle", W'(cmd_ready), W'(1));
    check_eq("abort_busy", W'(busy), '0);
    check_eq("abort_no_done", W'(done), '0);
    check_eq("abort_frozen", ca_q, g2);
    step();
    check_eq("abort_no_done2", W'(done), '0);
    check_eq("abort_frozen2", ca_q, g2);

    // Reset mid-run at gen4
    start_cmd("rst", g0, G'(8));
    snap("rst_g0", 0, g0, 1'b0);
    snap("rst_g1", 1, g1, 1'b0);
    snap("rst_g2", 2, g2, 1'b0);
    snap("rst_g3", 3, g3, 1'b0);
    reset = 1'b1;
    #1;
    check_eq("rst_load_in_reset", W'(ca_load), W'(1));
    check_eq("rst_gen4_data", snap_data, g4);
    step();
    check_reset_outputs("rst_mid");
    check_eq("rst_frozen", ca_q, g4);
    reset = 1'b0;
    step();
    check_eq("rst_no_done", W'(done), '0);
    start_cmd("rst_restart", g0, G'(3));
    snap("restart_g0", 0, g0, 1'b0);
    snap("restart_g1", 1, g1, 1'b0);
    snap("restart_g2", 2, g2, 1'b0);
    snap("restart_g3", 3, g3, 1'b1);
    check_end("restart_end", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
